// File: rtl/axi_sram_slv.sv
// axi_sram_slv: single-outstanding AXI slave on a single-port sync SRAM.
// One transaction at a time; AW/AR ties alternate between directions.
module axi_sram_slv #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [9:0]            s_awid,
  input  logic [31:0]           s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [9:0]            s_wid,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [9:0]            s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [9:0]            s_arid,
  input  logic [31:0]           s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [9:0]            s_rid,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [3:0]            sram_byte,
  output logic [31:0]           sram_di,
  input  logic [31:0]           sram_do
);

  typedef enum logic [2:0] {
    IDLE, WDATA, WRESP, RREQ, RDATA
  } state_t;

  state_t                state, state_nxt;
  logic                  en;
  logic                  last_w;
  logic [9:0]            id;
  logic [ADDR_WIDTH-1:0] cur, cur_nxt;
  logic [7:0]            len, cnt;
  logic                  fixed;
  logic [1:0]            err;
  logic                  wl_err;
  logic                  gnt_w, gnt_r;
  logic                  aw_hs, ar_hs;
  logic                  w_hs, r_hs;
  logic                  last, ok;
  logic [1:0]            resp, dec;
  logic [9:0]            a_id;
  logic [31:0]           a_addr;
  logic [7:0]            a_len;
  logic [2:0]            a_size;
  logic [1:0]            a_burst;
  logic                  unused;

  assign unused = ^{s_wid, a_addr[1:0]};

  // Ties go to the direction not granted last time
  assign gnt_w = s_awvalid & (~s_arvalid | ~last_w);
  assign gnt_r = s_arvalid & (~s_awvalid | last_w);
  assign s_awready = en & (state == IDLE) & gnt_w;
  assign s_arready = en & (state == IDLE) & gnt_r;
  assign aw_hs = s_awvalid & s_awready;
  assign ar_hs = s_arvalid & s_arready;

  assign a_id    = aw_hs ? s_awid    : s_arid;
  assign a_addr  = aw_hs ? s_awaddr  : s_araddr;
  assign a_len   = aw_hs ? s_awlen   : s_arlen;
  assign a_size  = aw_hs ? s_awsize  : s_arsize;
  assign a_burst = aw_hs ? s_awburst : s_arburst;

  always_comb begin
    dec = 2'b00;
    if (|a_addr[31:ADDR_WIDTH+2])
      dec = 2'b11;
    else if (a_size != 3'd2 || a_burst[1])
      dec = 2'b10;
  end

  assign w_hs    = (state == WDATA) & s_wvalid;
  assign r_hs    = (state == RDATA) & s_rready;
  assign last    = (cnt == len);
  assign ok      = (err == 2'b00);
  assign cur_nxt = fixed ? cur : cur + ADDR_WIDTH'(1);
  assign resp    = ok ? {wl_err, 1'b0} : err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      en     <= 1'b0;
      last_w <= 1'b1;
      id     <= '0;
      cur    <= '0;
      len    <= '0;
      cnt    <= '0;
      fixed  <= 1'b0;
      err    <= 2'b00;
      wl_err <= 1'b0;
    end else begin
      state <= state_nxt;
      en    <= 1'b1;
      if (aw_hs | ar_hs) begin
        last_w <= aw_hs;
        id     <= a_id;
        cur    <= a_addr[ADDR_WIDTH+1:2];
        len    <= a_len;
        fixed  <= (a_burst == 2'b00);
        cnt    <= '0;
        err    <= dec;
        wl_err <= 1'b0;
      end
      if (w_hs) begin
        cnt <= cnt + 8'd1;
        cur <= cur_nxt;
        if (s_wlast != last)
          wl_err <= 1'b1;
      end
      if (r_hs && !last) begin
        cnt <= cnt + 8'd1;
        cur <= cur_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bid     = '0;
    s_bresp   = 2'b00;
    s_rvalid  = 1'b0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    sram_a    = '0;
    sram_byte = 4'b0000;
    sram_di   = '0;
    unique case (state)
      IDLE: begin
        if (aw_hs)
          state_nxt = WDATA;
        else if (ar_hs)
          state_nxt = RREQ;
      end
      WDATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          if (ok) begin
            sram_cs   = 1'b1;
            sram_we   = 1'b1;
            sram_a    = cur;
            sram_byte = s_wstrb;
            sram_di   = s_wdata;
          end
          if (last)
            state_nxt = WRESP;
        end
      end
      WRESP: begin
        s_bvalid = 1'b1;
        s_bid    = id;
        s_bresp  = resp;
        if (s_bready)
          state_nxt = IDLE;
      end
      RREQ: begin
        sram_cs   = ok;
        sram_a    = ok ? cur : '0;
        state_nxt = RDATA;
      end
      RDATA: begin
        // SRAM stays deselected here so sram_do holds under backpressure
        s_rvalid = 1'b1;
        s_rid    = id;
        s_rresp  = resp;
        s_rdata  = ok ? sram_do : '0;
        s_rlast  = last;
        if (s_rready)
          state_nxt = last ? IDLE : RREQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slv.sv
// tb_axi_sram_slv: directed and random AXI traffic against a word-array
// memory model; SRAM behaviour is modelled next to the DUT.
module tb_axi_sram_slv;
  localparam int AW  = 14;
  localparam int NW  = 1 << AW;
  localparam int LIM = 300;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [9:0]    s_awid = '0;
  logic [31:0]   s_awaddr = '0;
  logic [7:0]    s_awlen = '0;
  logic [2:0]    s_awsize = '0;
  logic [1:0]    s_awburst = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [9:0]    s_wid = '0;
  logic [31:0]   s_wdata = '0;
  logic [3:0]    s_wstrb = '0;
  logic          s_wlast = 1'b0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [9:0]    s_bid;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b0;
  logic [9:0]    s_arid = '0;
  logic [31:0]   s_araddr = '0;
  logic [7:0]    s_arlen = '0;
  logic [2:0]    s_arsize = '0;
  logic [1:0]    s_arburst = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [9:0]    s_rid;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          s_rvalid;
  logic          s_rready = 1'b0;
  logic          sram_cs;
  logic          sram_we;
  logic [AW-1:0] sram_a;
  logic [3:0]    sram_byte;
  logic [31:0]   sram_di;
  logic [31:0]   sram_do = '0;

  axi_sram_slv #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_a(sram_a),
    .sram_byte(sram_byte), .sram_di(sram_di), .sram_do(sram_do)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                        logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  logic [31:0] mem [NW] = '{default: 32'h0};
  always @(posedge clk)
    if (sram_cs) begin
      if (sram_we)
        mem[sram_a] <= merge(mem[sram_a], sram_di, sram_byte);
      else
        sram_do <= mem[sram_a];
    end

  int cs_cnt = 0;
  int idle_viol = 0;
  always @(negedge clk)
    if (rstn) begin
      if (sram_cs) cs_cnt++;
      if (!sram_cs && (sram_we || |sram_byte || |sram_di)) idle_viol++;
    end

  logic [31:0] model [NW] = '{default: 32'h0};
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  int          errs = 0;
  int          checks = 0;
  int          t_hs = 0;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] dec(logic [31:0] addr, logic [2:0] size,
                                     logic [1:0] burst);
    if (addr >= (32'd1 << (AW + 2))) return 2'b11;
    if (size != 3'd2 || burst > 2'd1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int word_at(logic [31:0] addr, logic [1:0] burst, int k);
    logic [31:0] w;
    w = (addr >> 2) + ((burst == 2'b00) ? 32'd0 : 32'(k));
    return int'(w % NW);
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {s_awready, s_arready, s_wready, s_bvalid,
                        s_rvalid, s_rlast, sram_cs, sram_we}, 0);
    chk({tag, "_rdata"}, s_rdata, 0);
    chk({tag, "_ids"}, {s_bid, s_bresp, s_rid, s_rresp}, 0);
    chk({tag, "_sram"}, {sram_a, sram_byte, sram_di}, 0);
  endtask

  task automatic aw_hs(input logic [9:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    int n = 0;
    s_awid = id; s_awaddr = addr; s_awlen = len;
    s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
    #1;
    while (!s_awready && n < LIM) begin @(posedge clk); #1; n++; end
    chk("aw_timeout", n >= LIM, 0);
    t_hs = cyc;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic ar_hs(input logic [9:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    int n = 0;
    s_arid = id; s_araddr = addr; s_arlen = len;
    s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
    #1;
    while (!s_arready && n < LIM) begin @(posedge clk); #1; n++; end
    chk("ar_timeout", n >= LIM, 0);
    t_hs = cyc;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic w_txn(input logic [9:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input int bad, input int bp);
    int n;
    logic [1:0] e, d;
    int w;
    aw_hs(id, addr, len, size, burst);
    for (int k = 0; k <= int'(len); k++) begin
      s_wdata = wdat[k]; s_wstrb = wstb[k];
      s_wlast = (k == int'(len)) ^ (k == bad);
      s_wvalid = 1'b1;
      n = 0;
      #1;
      while (!s_wready && n < LIM) begin @(posedge clk); #1; n++; end
      chk("w_wait", n, 0);
      @(posedge clk); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    d = dec(addr, size, burst);
    e = (d == 2'b00 && bad >= 0) ? 2'b10 : d;
    n = 0;
    while (!s_bvalid && n < LIM) begin @(posedge clk); #1; n++; end
    chk("b_wait", n, 0);
    chk("b_id", s_bid, id);
    chk("b_resp", s_bresp, e);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("b_hold", {s_bvalid, s_bid, s_bresp}, {1'b1, id, e});
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    chk("b_done", s_bvalid, 0);
    if (d == 2'b00)
      for (int k = 0; k <= int'(len); k++) begin
        w = word_at(addr, burst, k);
        model[w] = merge(model[w], wdat[k], wstb[k]);
      end
  endtask

  task automatic r_txn(input logic [9:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic [2:0] size,
                       input logic [1:0] burst, input int bp_beat,
                       input int bp, input bit tchk, input int stop);
    int n, t0;
    logic [1:0] e;
    logic [31:0] x;
    ar_hs(id, addr, len, size, burst);
    t0 = t_hs;
    e = dec(addr, size, burst);
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!s_rvalid && n < LIM) begin @(posedge clk); #1; n++; end
      chk("r_wait", n, 1);
      if (tchk && k == int'(len)) chk("r_last_cyc", cyc - t0, 2 * (k + 1));
      x = (e != 2'b00) ? 32'h0 : model[word_at(addr, burst, k)];
      chk("r_data", s_rdata, x);
      chk("r_id", s_rid, id);
      chk("r_resp", s_rresp, e);
      chk("r_last", s_rlast, k == int'(len));
      last_rdata = s_rdata;
      if (k == bp_beat)
        for (int i = 0; i < bp; i++) begin
          @(posedge clk); #1;
          chk("r_hold", {s_rvalid, s_rlast, s_rid, s_rdata},
              {1'b1, k == int'(len), id, x});
        end
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
      if (k == stop) return;
    end
    chk("r_done", s_rvalid, 0);
  endtask

  initial begin
    int snap, wb, op, r, bpb, bpc;
    logic [31:0] a;
    logic [7:0] ln;
    logic [2:0] sz;
    logic [1:0] bu;

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");

    // Tie straight out of reset: read wins, and ready waits one clock
    rstn = 1'b1;
    s_araddr = 32'h80; s_arid = 10'h3A1; s_arlen = 8'd1;
    s_arsize = 3'd2; s_arburst = 2'b01; s_arvalid = 1'b1;
    s_awaddr = 32'h90; s_awid = 10'h155; s_awlen = 8'd0;
    s_awsize = 3'd2; s_awburst = 2'b01; s_awvalid = 1'b1;
    #1;
    chk("rdy_gated", {s_awready, s_arready}, 2'b00);
    @(posedge clk); #1;
    chk("tie1", {s_awready, s_arready}, 2'b01);
    r_txn(10'h3A1, 32'h80, 8'd1, 3'd2, 2'b01, -1, 0, 1'b1, -1);
    s_arid = 10'h2C2; s_araddr = 32'h90; s_arlen = 8'd0; s_arvalid = 1'b1;
    #1;
    chk("tie2", {s_awready, s_arready}, 2'b10);
    wdat[0] = 32'hCAFE0001; wstb[0] = 4'hF;
    w_txn(10'h155, 32'h90, 8'd0, 3'd2, 2'b01, -1, 0);
    r_txn(10'h2C2, 32'h90, 8'd0, 3'd2, 2'b01, -1, 0, 1'b1, -1);
    chk("tie_rd", last_rdata, 32'hCAFE0001);

    // 256-beat INCR burst wrapping the top of the word space
    for (int k = 0; k < 256; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
    w_txn(10'h011, (NW - 4) * 4, 8'd255, 3'd2, 2'b01, -1, 0);
    r_txn(10'h012, (NW - 4) * 4, 8'd255, 3'd2, 2'b01, -1, 0, 1'b1, -1);

    // Refill pattern
    for (int k = 0; k < 4; k++) begin
      wdat[k] = 32'h11111111 * (k + 1); wstb[k] = 4'hF;
    end
    w_txn(10'h004, 32'h40, 8'd3, 3'd2, 2'b01, -1, 0);
    r_txn(10'h005, 32'h40, 8'd3, 3'd2, 2'b01, -1, 0, 1'b1, -1);
    chk("refill_b4", last_rdata, 32'h44444444);

    // Byte-masked write with B backpressure
    wdat[0] = 32'hFFFFFFFF; wstb[0] = 4'hF;
    w_txn(10'h020, 32'h104, 8'd0, 3'd2, 2'b01, -1, 0);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0011;
    w_txn(10'h021, 32'h104, 8'd0, 3'd2, 2'b01, -1, 3);
    r_txn(10'h022, 32'h104, 8'd0, 3'd2, 2'b00, -1, 0, 1'b1, -1);
    chk("byte_rd", last_rdata, 32'hFFFFCCDD);

    // Error responses
    snap = cs_cnt;
    r_txn(10'h030, 32'h0001_0000, 8'd0, 3'd2, 2'b01, -1, 0, 1'b1, -1);
    chk("decerr_cs", cs_cnt - snap, 0);
    snap = cs_cnt;
    wdat[0] = 32'h12345678; wstb[0] = 4'hF;
    w_txn(10'h031, 32'h104, 8'd0, 3'd1, 2'b01, -1, 0);
    chk("slverr_cs", cs_cnt - snap, 0);
    r_txn(10'h032, 32'h104, 8'd0, 3'd2, 2'b01, -1, 0, 1'b0, -1);
    chk("slverr_mem", last_rdata, 32'hFFFFCCDD);
    for (int k = 0; k < 3; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
    w_txn(10'h033, 32'h300, 8'd2, 3'd2, 2'b01, 1, 0);

    // R backpressure mid-burst
    r_txn(10'h040, 32'h40, 8'd3, 3'd2, 2'b01, 1, 5, 1'b0, -1);

    // Random traffic in the initialised low region
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 1);
      wb = $urandom_range(0, 200);
      ln = 8'($urandom_range(0, 7));
      a  = 32'(wb * 4) | 32'($urandom_range(0, 3));
      sz = 3'd2;
      bu = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01;
      r  = $urandom_range(0, 11);
      if (r == 0) sz = 3'd1;
      if (r == 1) bu = 2'b10;
      if (r == 2) a = a | 32'h8000_0000;
      bpb = $urandom_range(0, 7);
      bpc = $urandom_range(0, 3);
      if (op == 0) begin
        for (int k = 0; k < 8; k++) begin
          wdat[k] = $urandom; wstb[k] = 4'($urandom_range(0, 15));
        end
        w_txn(10'($urandom), a, ln, sz, bu, -1, bpc);
      end else
        r_txn(10'($urandom), a, ln, sz, bu, bpb, bpc, 1'b0, -1);
    end

    // Reset in the middle of a read burst
    r_txn(10'h050, 32'h40, 8'd3, 3'd2, 2'b01, -1, 0, 1'b0, 1);
    rstn = 1'b0;
    #1;
    chk_quiet("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    r_txn(10'h051, 32'h40, 8'd3, 3'd2, 2'b01, -1, 0, 1'b1, -1);

    chk("idle_cmd", idle_viol, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
